uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of uart_rx. Accepts bytes over the rx

---
 rtl/uart_pkg.sv | 19 +
 rtl/fifo_sync.sv | 112 +++++++++++
 rtl/uart_rx_fifo.sv | 142 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Types shared by the UART receive buffer and its testbench.
//   uart_byte_t  : one received character (UART_DATA_W bits)
//   rxq_state_e  : rx handshake FSM states {IDLE, ACK, RELEASE}
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } rxq_state_e;

endpackage : uart_pkg

// File: rtl/fifo_sync.sv
// ---------------------------------------------------------------------------
// fifo_sync
//   Single-clock first-word-fall-through FIFO, 2**DEPTH_LOG2 entries.
//   The head byte is held in a register so it is defined out of reset and
//   keeps its last value when the FIFO drains.
// Ports
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_push, i_wr_data: write request and data
//   i_pop            : consume head (ignored when empty)
//   o_rd_data        : head byte (valid while !o_empty)
//   o_count          : entries held, registered
//   o_count_nxt      : value o_count takes at the next edge
//   o_empty, o_full  : fill status
//   o_drop           : push refused this cycle (full, no pop)
// ---------------------------------------------------------------------------
module fifo_sync #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_push,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic                  i_pop,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic [DEPTH_LOG2:0]   o_count_nxt,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_drop
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_inc;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  pop_ok, push_ok;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNT_FULL);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);
    assign o_drop  = i_push && o_full && !pop_ok;

    assign rd_ptr_inc = rd_ptr_q + 1'b1;

    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_inc;

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Next head: a push into an empty FIFO, or a pop of the last entry
        // coinciding with a push, bypasses storage (the slot is being
        // written this very edge); otherwise the successor comes from memory.
        if (o_empty) begin
            if (push_ok) rd_data_d = i_wr_data;
        end else if (pop_ok) begin
            if (count_q == CNT_ONE) begin
                if (push_ok) rd_data_d = i_wr_data;
            end else begin
                rd_data_d = mem[rd_ptr_inc];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data   = rd_data_q;
    assign o_count     = count_q;
    assign o_count_nxt = count_d;

endmodule : fifo_sync

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive buffer downstream of uart_rx. Takes bytes over the four-phase
//   ready/ack/ack-clear handshake and queues them in a FWFT FIFO for the CPU.
//   A byte arriving while the FIFO is full is dropped and flags a sticky
//   overrun; the handshake always completes so uart_rx never stalls.
// Configuration
//   RTS_FLOW_EN : when defined, o_rts_n goes high (stop sending) while the
//                 fill level is at or above HIWATER; otherwise o_rts_n = 0.
// Ports
//   i_clk, i_reset_n        : clock, asynchronous active-low reset
//   i_rx_data, i_data_rdy   : byte offer from uart_rx
//   o_rdy_ack, i_rdy_ack_clr: handshake acknowledge / release
//   o_rd_data, o_rd_valid   : head byte and FIFO-not-empty
//   i_rd_pop                : CPU consumes the head byte
//   o_count                 : entries held
//   o_overrun, i_overrun_clr: sticky drop flag and its clear
//   o_rts_n                 : flow control, 0 = send allowed
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int HIWATER    = 12
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_W-1:0]     i_rx_data,
    input  logic                  i_data_rdy,
    output logic                  o_rdy_ack,
    input  logic                  i_rdy_ack_clr,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_pop,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overrun,
    input  logic                  i_overrun_clr,
    output logic                  o_rts_n
);

    localparam logic [DEPTH_LOG2:0] HIWATER_CNT = HIWATER[DEPTH_LOG2:0];

    rxq_state_e          state_q, state_d;
    logic                rdy_ack_q, rdy_ack_d;
    logic                overrun_q, overrun_d;
    logic                capture;
    logic                fifo_empty, fifo_full, fifo_drop;
    logic [DEPTH_LOG2:0] count_nxt;

    // A byte is taken only on the IDLE->ACK transition, so each offer
    // produces exactly one push however long i_data_rdy stays high.
    assign capture = (state_q == IDLE) && i_data_rdy && !i_rdy_ack_clr;

    always_comb begin
        state_d   = state_q;
        rdy_ack_d = rdy_ack_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    rdy_ack_d = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (i_rdy_ack_clr) begin
                    rdy_ack_d = 1'b0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                if (!i_data_rdy && !i_rdy_ack_clr) state_d = IDLE;
            end
            default: begin
                rdy_ack_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Setting wins over a same-cycle clear so a drop is never lost.
    always_comb begin
        overrun_d = overrun_q;
        if (i_overrun_clr) overrun_d = 1'b0;
        if (fifo_drop)     overrun_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            rdy_ack_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_ack_q <= rdy_ack_d;
            overrun_q <= overrun_d;
        end
    end

    fifo_sync #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (capture),
        .i_wr_data   (i_rx_data),
        .i_pop       (i_rd_pop),
        .o_rd_data   (o_rd_data),
        .o_count     (o_count),
        .o_count_nxt (count_nxt),
        .o_empty     (fifo_empty),
        .o_full      (fifo_full),
        .o_drop      (fifo_drop)
    );

`ifdef RTS_FLOW_EN
    // Registered from the next count so RTS changes on the same edge as
    // o_count rather than one cycle behind it.
    logic rts_n_q, rts_n_d;
    logic unused_full;

    assign rts_n_d     = (count_nxt >= HIWATER_CNT);
    assign unused_full = fifo_full;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rts_n_q <= 1'b0;
        else            rts_n_q <= rts_n_d;
    end

    assign o_rts_n = rts_n_q;
`else
    logic unused_rts;
    assign unused_rts = ^{count_nxt, HIWATER_CNT, fifo_full};
    assign o_rts_n    = 1'b0;
`endif

    assign o_rdy_ack  = rdy_ack_q;
    assign o_rd_valid = !fifo_empty;
    assign o_overrun  = overrun_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. A uart_rx model drives the
//   four-phase handshake; accepted bytes go into a scoreboard queue and are
//   compared as the CPU side pops them. A vector table covers basic mixed
//   push/pop traffic; hand-written sequences cover the full/empty corners.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic        i_clk;
    logic        i_reset_n;
    uart_byte_t  i_rx_data;
    logic        i_data_rdy;
    logic        o_rdy_ack;
    logic        i_rdy_ack_clr;
    uart_byte_t  o_rd_data;
    logic        o_rd_valid;
    logic        i_rd_pop;
    logic [4:0]  o_count;
    logic        o_overrun;
    logic        i_overrun_clr;
    logic        o_rts_n;

    uart_rx_fifo #(
        .DATA_W     (8),
        .DEPTH_LOG2 (4),
        .HIWATER    (12)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_rx_data     (i_rx_data),
        .i_data_rdy    (i_data_rdy),
        .o_rdy_ack     (o_rdy_ack),
        .i_rdy_ack_clr (i_rdy_ack_clr),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .i_rd_pop      (i_rd_pop),
        .o_count       (o_count),
        .o_overrun     (o_overrun),
        .i_overrun_clr (i_overrun_clr),
        .o_rts_n       (o_rts_n)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    uart_byte_t exp_q[$];

    typedef enum logic {OP_PUSH, OP_POP} op_e;
    typedef struct {
        op_e        op;
        uart_byte_t data;
        logic [4:0] exp_count;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        bit ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (o_rdy_ack === lvl) ok = 1;
            else step();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic finish_hs();
        i_rdy_ack_clr = 1'b1;
        wait_ack(1'b0, "ack_fall");
        i_data_rdy = 1'b0;
        step();
        i_rdy_ack_clr = 1'b0;
        step();
    endtask

    // uart_rx model: offer one byte and complete the handshake. The
    // scoreboard keeps the byte only if the model FIFO has room.
    task automatic send(input uart_byte_t b);
        i_rx_data  = b;
        i_data_rdy = 1'b1;
        wait_ack(1'b1, "ack_rise");
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        finish_hs();
    endtask

    task automatic do_pop(input string name);
        if (exp_q.size() != 0) begin
            check({name, "_valid"}, 32'(o_rd_valid), 32'd1);
            check({name, "_data"}, 32'(o_rd_data), 32'(exp_q.pop_front()));
        end
        i_rd_pop = 1'b1;
        step();
        i_rd_pop = 1'b0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
        exp_q.delete();
        step();
    endtask

    initial begin
        vecs[0] = '{OP_POP,  8'h00, 5'd0, 1'b0};
        vecs[1] = '{OP_PUSH, 8'h3C, 5'd1, 1'b1};
        vecs[2] = '{OP_PUSH, 8'hC3, 5'd2, 1'b1};
        vecs[3] = '{OP_POP,  8'h00, 5'd1, 1'b1};
        vecs[4] = '{OP_PUSH, 8'h81, 5'd2, 1'b1};
        vecs[5] = '{OP_POP,  8'h00, 5'd1, 1'b1};
        vecs[6] = '{OP_POP,  8'h00, 5'd0, 1'b0};
        vecs[7] = '{OP_POP,  8'h00, 5'd0, 1'b0};
        vecs[8] = '{OP_PUSH, 8'hFF, 5'd1, 1'b1};
        vecs[9] = '{OP_POP,  8'h00, 5'd0, 1'b0};

        i_reset_n     = 1'b0;
        i_rx_data     = '0;
        i_data_rdy    = 1'b0;
        i_rdy_ack_clr = 1'b0;
        i_rd_pop      = 1'b0;
        i_overrun_clr = 1'b0;
        do_reset();

        check("rst_ack",   32'(o_rdy_ack),  32'd0);
        check("rst_valid", 32'(o_rd_valid), 32'd0);
        check("rst_data",  32'(o_rd_data),  32'h00);
        check("rst_count", 32'(o_count),    32'd0);
        check("rst_ovr",   32'(o_overrun),  32'd0);
        check("rst_rts",   32'(o_rts_n),    32'd0);

        // Single byte: ack and head appear exactly one edge after rdy.
        i_rx_data  = 8'hA5;
        i_data_rdy = 1'b1;
        #1;
        check("t1_ack_early", 32'(o_rdy_ack), 32'd0);
        step();
        check("t1_ack",   32'(o_rdy_ack),  32'd1);
        check("t1_valid", 32'(o_rd_valid), 32'd1);
        check("t1_data",  32'(o_rd_data),  32'hA5);
        check("t1_count", 32'(o_count),    32'd1);
        exp_q.push_back(8'hA5);
        finish_hs();
        check("t1_one_push", 32'(o_count), 32'd1);
        do_pop("t1_pop");

        // Vector table: mixed traffic, empty pops ignored.
        foreach (vecs[i]) begin
            if (vecs[i].op == OP_PUSH) send(vecs[i].data);
            else                       do_pop($sformatf("v%0d_pop", i));
            check($sformatf("v%0d_count", i), 32'(o_count),    32'(vecs[i].exp_count));
            check($sformatf("v%0d_valid", i), 32'(o_rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_ovr", i),   32'(o_overrun),  32'd0);
        end

        // Fill to capacity.
        for (int i = 0; i < DEPTH; i++) send(uart_byte_t'(i));
        check("t2_count", 32'(o_count),   32'd16);
        check("t2_ovr",   32'(o_overrun), 32'd0);
`ifndef RTS_FLOW_EN
        check("t2_rts",   32'(o_rts_n),   32'd0);
`endif

        // 17th byte is dropped but the handshake still completes.
        send(8'hEE);
        check("t3_ovr",   32'(o_overrun), 32'd1);
        check("t3_head",  32'(o_rd_data), 32'h00);
        check("t3_count", 32'(o_count),   32'd16);
        i_overrun_clr = 1'b1;
        step();
        i_overrun_clr = 1'b0;
        check("t3_clr", 32'(o_overrun), 32'd0);

        // Drop and clear on the same edge: the set wins.
        i_rx_data     = 8'hDD;
        i_data_rdy    = 1'b1;
        i_overrun_clr = 1'b1;
        step();
        i_overrun_clr = 1'b0;
        check("t3_set_prio", 32'(o_overrun), 32'd1);
        finish_hs();
        i_overrun_clr = 1'b1;
        step();
        i_overrun_clr = 1'b0;

        for (int i = 0; i < DEPTH; i++) do_pop($sformatf("t2_pop%0d", i));
        check("t2_empty_count", 32'(o_count),    32'd0);
        check("t2_empty_valid", 32'(o_rd_valid), 32'd0);
        check("t2_hold_data",   32'(o_rd_data),  32'h0F);

        // Pop on empty is ignored.
        i_rd_pop = 1'b1;
        step();
        i_rd_pop = 1'b0;
        check("t5_count", 32'(o_count),   32'd0);
        check("t5_data",  32'(o_rd_data), 32'h0F);

        // Full FIFO, push and pop on the same edge.
        for (int i = 0; i < DEPTH; i++) send(uart_byte_t'(8'h10 + i));
        check("t4_full", 32'(o_count), 32'd16);
        check("t4_head", 32'(o_rd_data), 32'(exp_q.pop_front()));
        i_rx_data  = 8'h55;
        i_data_rdy = 1'b1;
        i_rd_pop   = 1'b1;
        step();
        i_rd_pop = 1'b0;
        exp_q.push_back(8'h55);
        check("t4_count", 32'(o_count),   32'd16);
        check("t4_ovr",   32'(o_overrun), 32'd0);
        check("t4_ack",   32'(o_rdy_ack), 32'd1);
        finish_hs();
        for (int i = 0; i < DEPTH - 1; i++) do_pop($sformatf("t4_pop%0d", i));
        check("t4_last", 32'(o_rd_data), 32'h55);
        do_pop("t4_pop_last");
        check("t4_empty", 32'(o_rd_valid), 32'd0);

        // Reset while in ACK: ack drops without waiting for a clock edge.
        i_rx_data  = 8'h42;
        i_data_rdy = 1'b1;
        step();
        check("t5_in_ack", 32'(o_rdy_ack), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("t5_rst_ack",   32'(o_rdy_ack),  32'd0);
        check("t5_rst_count", 32'(o_count),    32'd0);
        check("t5_rst_data",  32'(o_rd_data),  32'h00);
        i_data_rdy = 1'b0;
        do_reset();

`ifdef RTS_FLOW_EN
        for (int i = 0; i < 11; i++) send(uart_byte_t'(8'h60 + i));
        check("t6_rts_11", 32'(o_rts_n), 32'd0);
        send(8'h6B);
        check("t6_count_12", 32'(o_count), 32'd12);
        check("t6_rts_12",   32'(o_rts_n), 32'd1);
        do_pop("t6_pop");
        check("t6_rts_back", 32'(o_rts_n), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_uart_rx_fifo
